// File: rtl/quad_wr_burst_arbiter.sv
// quad_wr_burst_arbiter: round-robin burst arbiter sharing one DDR write port among four quadrant channels
module quad_wr_burst_arbiter #(
  parameter int H_SIZE    = 960,
  parameter int V_SIZE    = 540,
  parameter int BURST_LEN = 64,
  parameter int LVL_W     = 11,
  parameter int ADDR_W    = 28
)(
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [3:0]        I_ch_vs,
  input  logic [4*LVL_W-1:0] I_ch_level,
  input  logic [127:0]      I_ch_data,
  output logic [3:0]        O_ch_rd_en,
  output logic              O_wr_req,
  input  logic              I_wr_ack,
  output logic [ADDR_W-1:0] O_wr_addr,
  output logic [7:0]        O_wr_len,
  input  logic              I_wr_data_req,
  output logic [31:0]       O_wr_data,
  input  logic              I_wr_done,
  output logic [1:0]        O_grant,
  output logic              O_busy
);
  localparam int XW = $clog2(H_SIZE + 1);
  localparam int YW = $clog2(V_SIZE);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {ARB, REQ, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] last_grant, grant, cand, idx;
  logic [XW-1:0] x [4];
  logic [YW-1:0] y [4];
  logic [3:0] vs_q, vs_pend, rise;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic found, pop, burst_full;
  assign rise = I_ch_vs & ~vs_q;
  assign pop = state == DATA && I_wr_data_req && beat < BW'(BURST_LEN);
  assign burst_full = beat + BW'(pop) == BW'(BURST_LEN);
  // Walk backwards so the channel nearest after last_grant wins
  always_comb begin
    found = 1'b0;
    cand = last_grant;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (I_ch_level[idx*LVL_W +: LVL_W] >= LVL_W'(BURST_LEN)) begin
        found = 1'b1;
        cand = idx;
      end
    end
    addr_nx = ADDR_W'(cand[1] ? V_SIZE * 2 * H_SIZE : 0) + ADDR_W'(cand[0] ? H_SIZE : 0)
            + ADDR_W'(y[cand]) * ADDR_W'(2 * H_SIZE) + ADDR_W'(x[cand]);
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) state <= ARB;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      ARB:     state_nx = found ? REQ : ARB;
      REQ:     state_nx = I_wr_ack ? DATA : REQ;
      DATA:    state_nx = I_wr_done && burst_full ? DONE : DATA;
      default: state_nx = ARB;
    endcase
    O_wr_req = state == REQ;
    O_busy = state != ARB;
    O_ch_rd_en = pop ? 4'(1) << grant : '0;
    O_wr_data = state == DATA ? I_ch_data[grant*32 +: 32] : '0;
    O_wr_len = 8'(BURST_LEN);
    O_grant = grant;
    O_wr_addr = addr;
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      last_grant <= 2'd3;
      grant <= '0;
      addr <= '0;
      beat <= '0;
      vs_q <= '0;
      vs_pend <= '0;
      for (int n = 0; n < 4; n++) begin
        x[n] <= '0;
        y[n] <= '0;
      end
    end else begin
      vs_q <= I_ch_vs;
      beat <= state == DATA ? beat + BW'(pop) : '0;
      if (state == ARB && found) begin
        grant <= cand;
        addr <= addr_nx;
      end
      if (state == DONE) last_grant <= grant;
      // A frame sync on the channel in flight is deferred until its burst retires
      for (int n = 0; n < 4; n++)
        if (state == DONE && grant == 2'(n)) begin
          vs_pend[n] <= rise[n];
          if (vs_pend[n]) begin
            x[n] <= '0;
            y[n] <= '0;
          end else if (x[n] == XW'(H_SIZE - BURST_LEN)) begin
            x[n] <= '0;
            y[n] <= y[n] == YW'(V_SIZE - 1) ? '0 : y[n] + YW'(1);
          end else x[n] <= x[n] + XW'(BURST_LEN);
        end else if (rise[n]) begin
          if (state != ARB && grant == 2'(n)) vs_pend[n] <= 1'b1;
          else begin
            x[n] <= '0;
            y[n] <= '0;
          end
        end
    end
endmodule

// File: tb/tb_quad_wr_burst_arbiter.sv
// tb_quad_wr_burst_arbiter: randomized bench with a burst-index address model and round-robin model
module tb_quad_wr_burst_arbiter;
  localparam int H = 960, V = 540, BL = 64, LW = 11, AW = 28;
  logic clk = 0, rst_n = 0;
  logic [3:0] ch_vs = 0;
  logic [4*LW-1:0] ch_level;
  logic [127:0] ch_data;
  logic [3:0] rd_en;
  logic wr_req, wr_ack = 0, wr_data_req = 0, wr_done = 0, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_len;
  logic [31:0] wr_data;
  logic [1:0] grant;
  logic [AW-1:0] s_addr;
  logic [3:0] s_rd;
  logic [31:0] s_data;
  logic [7:0] s_len;
  logic [1:0] s_grant;
  logic s_req, s_busy;
  int lvl[4], cnt[4], kb[4];
  bit pend[4];
  int last_g = 3, cmp = 0, errs = 0;

  always #5 clk = ~clk;
  always_comb
    for (int n = 0; n < 4; n++) begin
      ch_level[n*LW +: LW] = LW'(lvl[n]);
      ch_data[n*32 +: 32] = {8'(n), 24'(cnt[n])};
    end
  always @(posedge clk)
    for (int n = 0; n < 4; n++) if (rd_en[n]) cnt[n] <= cnt[n] + 1;

  quad_wr_burst_arbiter dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_ch_vs(ch_vs), .I_ch_level(ch_level), .I_ch_data(ch_data),
    .O_ch_rd_en(rd_en), .O_wr_req(wr_req), .I_wr_ack(wr_ack), .O_wr_addr(wr_addr), .O_wr_len(wr_len),
    .I_wr_data_req(wr_data_req), .O_wr_data(wr_data), .I_wr_done(wr_done), .O_grant(grant), .O_busy(busy));

  // Small frame so a full frame wrap fits in a short run; ch0 always full, controller always ready
  quad_wr_burst_arbiter #(.H_SIZE(128), .V_SIZE(3)) dut_s (
    .I_clk(clk), .I_rst_n(rst_n), .I_ch_vs(4'b0), .I_ch_level({{(3*LW){1'b0}}, LW'(64)}), .I_ch_data(128'd0),
    .O_ch_rd_en(s_rd), .O_wr_req(s_req), .I_wr_ack(s_req), .O_wr_addr(s_addr), .O_wr_len(s_len),
    .I_wr_data_req(1'b1), .O_wr_data(s_data), .I_wr_done(1'b1), .O_grant(s_grant), .O_busy(s_busy));

  function automatic int pick();
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last_g + k) % 4;
      if (lvl[c] >= BL) return c;
    end
    return -1;
  endfunction

  function automatic int exp_addr(int c);
    return (c / 2) * V * 2 * H + (c % 2) * H + (kb[c] / (H / BL)) * 2 * H + (kb[c] % (H / BL)) * BL;
  endfunction

  task automatic do_reset();
    rst_n = 0; ch_vs = 0; wr_ack = 0; wr_done = 0; wr_data_req = 0;
    for (int n = 0; n < 4; n++) begin lvl[n] = 0; kb[n] = 0; pend[n] = 0; end
    last_g = 3;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_burst(input int mode, input logic [3:0] vs_mask, output int addr_o, output int g_o);
    int g, n, pops;
    g = pick();
    addr_o = -1; g_o = -1;
    n = 0;
    while (!wr_req && n < 50) begin @(negedge clk); n++; end
    cmp++;
    if (!wr_req) begin errs++; $display("FAIL req_timeout: wr_req=%b required 1", wr_req); return; end
    addr_o = int'(wr_addr); g_o = int'(grant);
    cmp++;
    if (grant !== 2'(g)) begin errs++; $display("FAIL grant: got %0d required %0d", grant, g); end
    cmp++;
    if (wr_addr !== AW'(exp_addr(g))) begin errs++; $display("FAIL addr: got %0d required %0d (ch%0d)", wr_addr, exp_addr(g), g); end
    cmp++;
    if (wr_len !== 8'(BL)) begin errs++; $display("FAIL len: got %0d required %0d", wr_len, BL); end
    if (mode == 2) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cmp++;
      if (!wr_req || wr_addr !== AW'(addr_o)) begin errs++; $display("FAIL req_hold: req=%b addr=%0d required 1/%0d", wr_req, wr_addr, addr_o); end
    end
    wr_ack = 1; @(negedge clk); wr_ack = 0;
    pops = 0; n = 0;
    while (pops < BL && n < 500) begin
      wr_data_req = mode == 0 ? 1'b1 : mode == 1 ? n % 2 == 0 : $urandom_range(0, 1) == 1;
      wr_done = mode == 0 && pops == BL - 1;
      if (n == 10) begin
        ch_vs = vs_mask;
        for (int c = 0; c < 4; c++) if (vs_mask[c]) begin if (c == g) pend[c] = 1; else kb[c] = 0; end
      end
      if (n == 11) ch_vs = 0;
      #1;
      if (|rd_en) begin
        cmp++;
        if (rd_en !== 4'(1 << g) || wr_data !== {8'(g), 24'(cnt[g])}) begin
          errs++; $display("FAIL beat%0d: rd_en=%b data=%h required %b/%h", pops, rd_en, wr_data, 4'(1 << g), {8'(g), 24'(cnt[g])});
        end
        pops++;
      end
      @(negedge clk); n++;
    end
    ch_vs = 0;
    if (mode != 0) begin
      repeat (3) begin wr_data_req = 1; #1; if (|rd_en) pops++; @(negedge clk); end
      wr_data_req = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wr_done = 1; @(negedge clk);
    end
    wr_done = 0; wr_data_req = 0;
    cmp++;
    if (pops !== BL) begin errs++; $display("FAIL pops: got %0d required %0d", pops, BL); end
    cmp++;
    if (busy !== 1'b1 || wr_req !== 1'b0) begin errs++; $display("FAIL done_state: busy=%b req=%b required 1/0", busy, wr_req); end
    last_g = g;
    kb[g] = pend[g] ? 0 : (kb[g] + 1) % (V * H / BL);
    pend[g] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++;
    if ({wr_req, rd_en, busy, grant, wr_addr, wr_data} !== '0) begin
      errs++; $display("FAIL reset_outs: req=%b rd=%b busy=%b g=%0d addr=%0d data=%h required all 0", wr_req, rd_en, busy, grant, wr_addr, wr_data);
    end
    cmp++;
    if (wr_len !== 8'd64) begin errs++; $display("FAIL reset_len: got %0d required 64", wr_len); end
  endtask

  task automatic test_idle_ignore();
    do_reset();
    lvl[0] = 63;
    repeat (6) begin
      wr_ack = 1'($urandom_range(0, 1)); wr_done = 1'($urandom_range(0, 1)); wr_data_req = 1;
      @(negedge clk);
      cmp++;
      if (busy !== 1'b0 || wr_req !== 1'b0 || rd_en !== 4'b0) begin
        errs++; $display("FAIL idle: busy=%b req=%b rd=%b required 0/0/0", busy, wr_req, rd_en);
      end
    end
    wr_ack = 0; wr_done = 0; wr_data_req = 0;
  endtask

  task automatic test_latency();
    int a, g;
    do_reset();
    lvl[2] = 64;
    @(negedge clk);
    cmp++;
    if (wr_req !== 1'b1 || grant !== 2'd2 || wr_addr !== AW'(1036800) || wr_len !== 8'd64) begin
      errs++; $display("FAIL latency: req=%b g=%0d addr=%0d len=%0d required 1/2/1036800/64", wr_req, grant, wr_addr, wr_len);
    end
    run_burst(0, 4'b0, a, g);
  endtask

  task automatic test_round_robin();
    int a, g;
    do_reset();
    for (int n = 0; n < 4; n++) lvl[n] = 200;
    for (int i = 0; i < 6; i++) begin
      run_burst(0, 4'b0, a, g);
      cmp++;
      if (g !== i % 4) begin errs++; $display("FAIL rr_order%0d: got %0d required %0d", i, g, i % 4); end
    end
  endtask

  task automatic test_line_wrap();
    int a, g;
    do_reset();
    lvl[1] = 200;
    for (int i = 0; i < 16; i++) run_burst(2, 4'b0, a, g);
    cmp++;
    if (a !== 2880) begin errs++; $display("FAIL line_wrap: got %0d required 2880", a); end
  endtask

  task automatic test_vs();
    int a, g;
    do_reset();
    lvl[1] = 200; lvl[3] = 200;
    for (int i = 0; i < 5; i++) run_burst(0, 4'b0, a, g);
    run_burst(0, 4'b1010, a, g);
    run_burst(0, 4'b0, a, g);
    cmp++;
    if (a !== 960) begin errs++; $display("FAIL vs_ch1: got %0d required 960", a); end
    run_burst(0, 4'b0, a, g);
    cmp++;
    if (a !== 1037760) begin errs++; $display("FAIL vs_ch3: got %0d required 1037760", a); end
  endtask

  task automatic test_toggle();
    int a, g;
    do_reset();
    lvl[0] = 200;
    run_burst(1, 4'b0, a, g);
    run_burst(1, 4'b0, a, g);
  endtask

  task automatic test_random();
    int a, g;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int n = 0; n < 4; n++) lvl[n] = $urandom_range(0, 1) ? $urandom_range(64, 400) : $urandom_range(0, 63);
      if (pick() < 0) lvl[$urandom_range(0, 3)] = 64;
      run_burst(2, $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'b0, a, g);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    lvl[0] = 200;
    n = 0;
    while (!wr_req && n < 50) begin @(negedge clk); n++; end
    wr_ack = 1; @(negedge clk); wr_ack = 0;
    wr_data_req = 1;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    cmp++;
    if ({wr_req, rd_en, busy, wr_data, wr_addr, grant} !== '0) begin
      errs++; $display("FAIL reset_mid: req=%b rd=%b busy=%b data=%h addr=%0d g=%0d required all 0", wr_req, rd_en, busy, wr_data, wr_addr, grant);
    end
    wr_data_req = 0;
    do_reset();
  endtask

  task automatic test_frame_wrap();
    int n, k;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      n = 0;
      while (!s_req && n < 200) begin @(negedge clk); n++; end
      k = i % 6;
      cmp++;
      if (!s_req || s_addr !== AW'((k / 2) * 256 + (k % 2) * 64)) begin
        errs++; $display("FAIL frame_wrap%0d: req=%b addr=%0d required 1/%0d", i, s_req, s_addr, (k / 2) * 256 + (k % 2) * 64);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_latency();
    test_round_robin();
    test_line_wrap();
    test_vs();
    test_toggle();
    test_random();
    test_reset_mid();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
